// File: rtl/cycle_sequencer.sv
// cycle_sequencer: CPU T-state counter and opcode-fetch control.
// Tracks reset, fetch, execute, WAI and STP phases. Generates SYNC, the IR
// load strobe, PC increment and forced-BRK injection for RESET/NMI/IRQ.
// Honours RDY stalls on read cycles.
module cycle_sequencer #(
  parameter int unsigned RESET_CYCLES = 7,
  parameter int unsigned TSTATE_W     = 3
) (
  input  logic                fclk,
  input  logic                resb,
  input  logic                phi2,
  input  logic                rdy,
  input  logic                rw,
  input  logic                last_cycle,
  input  logic [7:0]          opcode,
  input  logic                nmib,
  input  logic                irqb,
  input  logic                i_flag,
  output logic [TSTATE_W-1:0] t_state,
  output logic                sync,
  output logic                ir_signal,
  output logic                force_brk,
  output logic                pc_inc,
  output logic [1:0]          int_kind,
  output logic                halted
);

  typedef enum logic [2:0] {
    ST_RST,
    ST_FETCH,
    ST_EXEC,
    ST_WAI,
    ST_STP
  } state_e;

  typedef enum logic [1:0] {
    INT_NONE  = 2'b00,
    INT_IRQ   = 2'b01,
    INT_NMI   = 2'b10,
    INT_RESET = 2'b11
  } int_e;

  localparam logic [7:0]          OP_WAI  = 8'hCB;
  localparam logic [7:0]          OP_STP  = 8'hDB;
  localparam logic [TSTATE_W-1:0] T_ONE   = TSTATE_W'(1);
  localparam logic [TSTATE_W-1:0] T_LAST  = '1;
  localparam logic [3:0]          RST_END = 4'(RESET_CYCLES - 1);

  state_e              state_q,     state_d;
  logic [TSTATE_W-1:0] t_state_q,   t_state_d;
  logic [3:0]          rst_cnt_q,   rst_cnt_d;
  logic                sync_q,      sync_d;
  logic                ir_q,        ir_d;
  logic                brk_q,       brk_d;
  logic                pc_inc_q,    pc_inc_d;
  int_e                kind_q,      kind_d;
  logic                halted_q,    halted_d;
  logic                nmi_pend_q,  nmi_pend_d;
  logic                nmib_prev_q, nmib_prev_d;

  logic stall;
  logic adv;
  logic nmi_edge;
  logic nmi_clear;
  logic take_fetch;
  logic take_fetch_plain;
  int_e fetch_kind;
  int_e entry_kind;

  // Stall, advance and NMI edge qualification for the current fclk edge
  always_comb begin
    stall    = ~rdy & rw & ((state_q == ST_RST) | (state_q == ST_FETCH) |
                            (state_q == ST_EXEC));
    adv      = phi2 & ~stall;
    nmi_edge = phi2 & nmib_prev_q & ~nmib;
    if (nmi_pend_q) begin
      fetch_kind = INT_NMI;
    end else if (~irqb & ~i_flag) begin
      fetch_kind = INT_IRQ;
    end else begin
      fetch_kind = INT_NONE;
    end
  end

  // Next-state and next-output computation; all outputs are registered
  always_comb begin
    state_d          = state_q;
    t_state_d        = t_state_q;
    rst_cnt_d        = rst_cnt_q;
    sync_d           = sync_q;
    ir_d             = ir_q;
    brk_d            = brk_q;
    pc_inc_d         = pc_inc_q;
    kind_d           = kind_q;
    halted_d         = halted_q;
    take_fetch       = 1'b0;
    take_fetch_plain = 1'b0;
    nmi_clear        = 1'b0;
    entry_kind       = INT_NONE;
    nmib_prev_d      = phi2 ? nmib : nmib_prev_q;

    if (adv) begin
      unique case (state_q)
        ST_RST: begin
          if (rst_cnt_q == RST_END) begin
            take_fetch_plain = 1'b1;
          end else begin
            rst_cnt_d = rst_cnt_q + 4'd1;
            t_state_d = t_state_q + T_ONE;
            brk_d     = 1'b1;
            kind_d    = INT_RESET;
          end
        end
        ST_FETCH: begin
          state_d   = ST_EXEC;
          t_state_d = T_ONE;
          sync_d    = 1'b0;
          ir_d      = 1'b0;
          pc_inc_d  = 1'b0;
        end
        ST_EXEC: begin
          // WAI/STP are only honoured for real opcodes, never for injected BRK
          if ((t_state_q == T_ONE) && !brk_q && (opcode == OP_WAI)) begin
            state_d  = ST_WAI;
            halted_d = 1'b1;
          end else if ((t_state_q == T_ONE) && !brk_q && (opcode == OP_STP)) begin
            state_d  = ST_STP;
            halted_d = 1'b1;
          end else if (last_cycle || (t_state_q == T_LAST)) begin
            take_fetch = 1'b1;
          end else begin
            t_state_d = t_state_q + T_ONE;
          end
        end
        ST_WAI: begin
          if (nmi_pend_q || !irqb) begin
            take_fetch = 1'b1;
          end
        end
        ST_STP: begin
          state_d = ST_STP;
        end
        default: begin
          state_d = ST_RST;
        end
      endcase
    end

    // Common entry into the opcode fetch cycle; leaving reset never injects
    if (take_fetch || take_fetch_plain) begin
      entry_kind = take_fetch_plain ? INT_NONE : fetch_kind;
      state_d    = ST_FETCH;
      t_state_d  = '0;
      rst_cnt_d  = '0;
      sync_d     = 1'b1;
      ir_d       = 1'b1;
      halted_d   = 1'b0;
      kind_d     = entry_kind;
      brk_d      = (entry_kind != INT_NONE);
      pc_inc_d   = (entry_kind == INT_NONE);
      nmi_clear  = (entry_kind == INT_NMI);
    end

    // A fresh edge in the same cycle as the clear wins
    nmi_pend_d = (nmi_pend_q & ~nmi_clear) | nmi_edge;
  end

  // State and output registers with asynchronous active-low reset
  always_ff @(posedge fclk or negedge resb) begin
    if (!resb) begin
      state_q     <= ST_RST;
      t_state_q   <= '0;
      rst_cnt_q   <= '0;
      sync_q      <= 1'b0;
      ir_q        <= 1'b0;
      brk_q       <= 1'b0;
      pc_inc_q    <= 1'b0;
      kind_q      <= INT_RESET;
      halted_q    <= 1'b0;
      nmi_pend_q  <= 1'b0;
      nmib_prev_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      t_state_q   <= t_state_d;
      rst_cnt_q   <= rst_cnt_d;
      sync_q      <= sync_d;
      ir_q        <= ir_d;
      brk_q       <= brk_d;
      pc_inc_q    <= pc_inc_d;
      kind_q      <= kind_d;
      halted_q    <= halted_d;
      nmi_pend_q  <= nmi_pend_d;
      nmib_prev_q <= nmib_prev_d;
    end
  end

  assign t_state   = t_state_q;
  assign sync      = sync_q;
  assign ir_signal = ir_q;
  assign force_brk = brk_q;
  assign pc_inc    = pc_inc_q;
  assign int_kind  = kind_q;
  assign halted    = halted_q;

endmodule

// File: tb/tb_cycle_sequencer.sv
// Bench for cycle_sequencer: directed scenarios with literal expectations,
// then randomized traffic, all outputs compared every fclk against a model.
module tb_cycle_sequencer;

  localparam int RC = 7;
  localparam int TW = 3;

  logic          fclk = 1'b0;
  logic          resb;
  logic          phi2;
  logic          rdy;
  logic          rw;
  logic          last_cycle;
  logic [7:0]    opcode;
  logic          nmib;
  logic          irqb;
  logic          i_flag;
  logic [TW-1:0] t_state;
  logic          sync;
  logic          ir_signal;
  logic          force_brk;
  logic          pc_inc;
  logic [1:0]    int_kind;
  logic          halted;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  cycle_sequencer #(.RESET_CYCLES(RC), .TSTATE_W(TW)) dut (
    .fclk(fclk), .resb(resb), .phi2(phi2), .rdy(rdy), .rw(rw),
    .last_cycle(last_cycle), .opcode(opcode), .nmib(nmib), .irqb(irqb),
    .i_flag(i_flag), .t_state(t_state), .sync(sync), .ir_signal(ir_signal),
    .force_brk(force_brk), .pc_inc(pc_inc), .int_kind(int_kind), .halted(halted)
  );

  always #5 fclk = ~fclk;

  task automatic chk(input string nm, input logic [7:0] act, input int exp);
    checks++;
    if (act !== 8'(exp)) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: reset countdown, position in instruction, halt kind,
  // injection kind of the running instruction, NMI latch.
  int m_left = RC;
  int m_cyc  = 0;
  int m_halt = 0;
  int m_inj  = 3;
  bit m_pend = 1'b0;
  bit m_nlast = 1'b1;
  bit mo_edge, mo_adv, mo_clr;
  int mo_next;

  always @(posedge fclk or negedge resb) begin
    if (!resb) begin
      m_left = RC; m_cyc = 0; m_halt = 0; m_inj = 3; m_pend = 0; m_nlast = 1;
    end else if (phi2) begin
      mo_edge = m_nlast && !nmib;
      m_nlast = nmib;
      mo_clr  = 0;
      mo_adv  = !(!rdy && rw && m_halt == 0);
      mo_next = m_pend ? 2 : ((!irqb && !i_flag) ? 1 : 0);
      if (m_left > 0) begin
        if (mo_adv) begin
          if (m_left == 1) begin m_left = 0; m_cyc = 0; m_inj = 0; end
          else m_left--;
        end
      end else if (m_halt == 2) begin
        m_halt = 2;
      end else if (m_halt == 1) begin
        if (m_pend || !irqb) begin
          m_halt = 0; m_cyc = 0; m_inj = mo_next; mo_clr = (mo_next == 2);
        end
      end else if (mo_adv) begin
        if (m_cyc == 0) m_cyc = 1;
        else if (m_cyc == 1 && m_inj == 0 && opcode == 8'hCB) m_halt = 1;
        else if (m_cyc == 1 && m_inj == 0 && opcode == 8'hDB) m_halt = 2;
        else if (last_cycle || m_cyc == 7) begin
          m_cyc = 0; m_inj = mo_next; mo_clr = (mo_next == 2);
        end else m_cyc++;
      end
      m_pend = (m_pend && !mo_clr) || mo_edge;
    end
  end

  // Per-cycle comparison of every output against the model
  always @(negedge fclk) begin
    if (cmp_en) begin
      automatic bit in_rst = (m_left > 0);
      automatic int e_t    = in_rst ? ((RC - m_left) % 8) : m_cyc;
      automatic bit e_sync = !in_rst && m_halt == 0 && m_cyc == 0;
      automatic bit e_brk  = in_rst ? (m_left < RC) : (m_halt == 0 && m_inj != 0);
      chk("t_state", t_state, e_t);
      chk("sync", sync, e_sync);
      chk("ir_signal", ir_signal, e_sync);
      chk("force_brk", force_brk, e_brk);
      chk("pc_inc", pc_inc, e_sync && m_inj == 0);
      chk("int_kind", int_kind, m_inj);
      chk("halted", halted, m_halt != 0);
    end
  end

  task automatic strobe();
    @(negedge fclk); phi2 = 1'b1;
    @(negedge fclk); phi2 = 1'b0;
    repeat (2) @(negedge fclk);
  endtask

  task automatic pulse_reset();
    @(negedge fclk); #2 resb = 1'b0;
    repeat (2) @(negedge fclk);
    #2 resb = 1'b1;
  endtask

  int cur_len = 2;
  int r;

  initial begin
    resb = 1'b0; phi2 = 1'b0; rdy = 1'b1; rw = 1'b1; last_cycle = 1'b0;
    opcode = 8'hEA; nmib = 1'b1; irqb = 1'b1; i_flag = 1'b1;
    repeat (2) @(negedge fclk);
    cmp_en = 1'b1;
    chk("rst_t_state", t_state, 0);
    chk("rst_int_kind", int_kind, 3);
    chk("rst_sync", sync, 0);
    chk("rst_force_brk", force_brk, 0);
    chk("rst_halted", halted, 0);
    #2 resb = 1'b1;

    // reset sequence
    for (int k = 0; k < RC; k++) begin
      chk("rstseq_t", t_state, k);
      chk("rstseq_kind", int_kind, 3);
      if (k > 0) chk("rstseq_brk", force_brk, 1);
      strobe();
    end
    chk("first_sync", sync, 1);
    chk("first_t", t_state, 0);
    chk("first_kind", int_kind, 0);
    chk("first_pc_inc", pc_inc, 1);

    // two-cycle instruction A9
    opcode = 8'hA9;
    strobe();
    chk("a9_t1", t_state, 1);
    chk("a9_ir_low", ir_signal, 0);
    last_cycle = 1'b1;
    strobe();
    chk("a9_t0", t_state, 0);
    chk("a9_ir_high", ir_signal, 1);
    chk("a9_pc_inc", pc_inc, 1);

    // RDY stall on read
    last_cycle = 1'b0;
    strobe(); strobe();
    rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      strobe();
      chk("stall_t", t_state, 2);
    end
    rdy = 1'b1;
    strobe();
    chk("stall_resume", t_state, 3);

    // RDY low on write cycle does not stall
    last_cycle = 1'b1; strobe();
    last_cycle = 1'b0; strobe(); strobe();
    rdy = 1'b0; rw = 1'b0;
    strobe();
    chk("write_nostall", t_state, 3);
    rdy = 1'b1; rw = 1'b1;

    // illegal-opcode wrap guard
    repeat (4) strobe();
    chk("wrap_t7", t_state, 7);
    strobe();
    chk("wrap_t0", t_state, 0);
    chk("wrap_sync", sync, 1);

    // NMI during EXEC with IRQ also pending
    strobe();
    nmib = 1'b0; irqb = 1'b0; i_flag = 1'b0;
    strobe();
    last_cycle = 1'b1;
    strobe();
    chk("nmi_kind", int_kind, 2);
    chk("nmi_brk", force_brk, 1);
    chk("nmi_pc_inc", pc_inc, 0);
    last_cycle = 1'b0; strobe();
    chk("nmi_exec_kind", int_kind, 2);
    last_cycle = 1'b1; strobe();
    chk("irq_kind", int_kind, 1);
    chk("irq_brk", force_brk, 1);
    irqb = 1'b1; nmib = 1'b1; i_flag = 1'b1;
    last_cycle = 1'b0; strobe();
    last_cycle = 1'b1; strobe();
    chk("post_irq_kind", int_kind, 0);

    // WAI, resumed by masked IRQ without injection
    last_cycle = 1'b0; opcode = 8'hCB;
    strobe(); strobe();
    repeat (10) strobe();
    chk("wai_halted", halted, 1);
    chk("wai_t_held", t_state, 1);
    irqb = 1'b0;
    strobe();
    chk("wai_exit_halted", halted, 0);
    chk("wai_exit_sync", sync, 1);
    chk("wai_exit_kind", int_kind, 0);
    chk("wai_exit_pc_inc", pc_inc, 1);
    irqb = 1'b1;

    // STP ignores NMI and IRQ
    opcode = 8'hDB;
    strobe(); strobe();
    nmib = 1'b0; irqb = 1'b0; i_flag = 1'b0;
    repeat (5) strobe();
    chk("stp_halted", halted, 1);
    chk("stp_sync", sync, 0);
    pulse_reset();
    chk("stp_reset_kind", int_kind, 3);
    chk("stp_reset_halted", halted, 0);
    chk("stp_reset_t", t_state, 0);
    nmib = 1'b1; irqb = 1'b1; i_flag = 1'b1; opcode = 8'hEA;

    // randomized traffic
    for (int n = 0; n < 2000; n++) begin
      if ((m_halt == 2 && $urandom_range(0, 7) == 0) || $urandom_range(0, 499) == 0)
        pulse_reset();
      if (m_left == 0 && m_halt == 0 && m_cyc == 0) begin
        cur_len = $urandom_range(2, 9);
        r = $urandom_range(0, 39);
        if (r == 0) opcode = 8'hCB;
        else if (r == 1) opcode = 8'hDB;
        else begin
          opcode = 8'($urandom_range(0, 255));
          if (opcode == 8'hCB || opcode == 8'hDB) opcode = 8'hEA;
        end
      end
      last_cycle = (m_left == 0 && m_halt == 0 && m_cyc == cur_len - 1);
      rdy    = ($urandom_range(0, 9) != 0);
      rw     = 1'($urandom_range(0, 1));
      irqb   = ($urandom_range(0, 7) != 0);
      i_flag = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) nmib = ~nmib;
      strobe();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cycle_sequencer.md
Name: cycle_sequencer

Overview:
- Sits directly upstream of the instruction register and downstream of the opcode decoder.
- Owns the CPU cycle (T-state) counter and generates the `ir_signal` load strobe that captures the opcode byte.
- Drives SYNC, PC-increment and interrupt/reset injection (forced BRK opcode).
- Implements RDY stall plus WAI/STP low-power states.
- The opcode decoder consumes `t_state` and returns `last_cycle` to close each instruction.

Parameters:
- `RESET_CYCLES`, 7, number of CPU cycles in the reset sequence before the first opcode fetch (range 2..15).
- `TSTATE_W`, 3, width of the `t_state` counter; instructions longer than 2^TSTATE_W cycles are illegal.

Ports:
- `fclk`  in  1  system clock; all state changes on the rising edge.
- `resb`  in  1  asynchronous active-low reset.
- `phi2`  in  1  CPU cycle strobe, one `fclk` wide; state advances only on `fclk` edges where `phi2`=1.
- `rdy`  in  1  1=advance; 0=stall on a read cycle.
- `rw`  in  1  current bus direction from decoder (1=read); a stall only applies when `rw`=1.
- `last_cycle`  in  1  from decoder: current T-state is the final cycle of the instruction.
- `opcode`  in  8  instruction register output (decoded opcode).
- `nmib`  in  1  active-low NMI, edge triggered.
- `irqb`  in  1  active-low IRQ, level.
- `i_flag`  in  1  processor status I bit.
- `t_state`  out  TSTATE_W  current cycle within instruction; 0 = opcode fetch.
- `sync`  out  1  high during the opcode fetch cycle.
- `ir_signal`  out  1  load strobe to instruction register.
- `force_brk`  out  1  instruction register must load 8'h00 instead of the data bus.
- `pc_inc`  out  1  increment PC this cycle.
- `int_kind`  out  2  00 none/BRK, 01 IRQ, 10 NMI, 11 RESET; held for the whole injected sequence.
- `halted`  out  1  high in WAI or STP.

Behaviour:
- States: RST, FETCH, EXEC, WAI, STP.
- Reset values (`resb`=0): state=RST, cycle counter=0, `t_state`=0, `sync`=0, `ir_signal`=0, `force_brk`=0, `pc_inc`=0, `int_kind`=11, `halted`=0, `nmi_pending`=0.
  - `resb` low mid-instruction aborts immediately to these values.
- Advance rule:
  - On an `fclk` edge with `phi2`=1, unless (`rdy`=0 and `rw`=1 and state ∈ {FETCH, EXEC, RST}).
  - During a stall all registers hold; `sync` and `ir_signal` hold their values.
- RST:
  - Counts `RESET_CYCLES`−1 advances.
  - `force_brk`=1, `int_kind`=11, `t_state` counts from 0 to `RESET_CYCLES`−1.
  - Then FETCH with `int_kind`=00.
- FETCH (`t_state`=0):
  - `sync`=1; `ir_signal`=1 for the whole cycle.
  - If no interrupt is pending: `pc_inc`=1, `force_brk`=0.
  - If `nmi_pending`: `force_brk`=1, `pc_inc`=0, `int_kind`=10.
  - Else if `irqb`=0 and `i_flag`=0: same, with `int_kind`=01.
  - Priority is RESET > NMI > IRQ.
  - On advance go to EXEC with `t_state`=1.
- EXEC:
  - `sync`=0, `ir_signal`=0.
  - On advance: if `last_cycle`=1, go to FETCH with `t_state`=0; else `t_state`+1.
  - If `t_state` would wrap past 2^TSTATE_W−1, go to FETCH. This is an illegal-opcode guard and must not hang.
  - On the advance out of `t_state`=1:
    - If `opcode`=CB (WAI) and `force_brk`=0, go to WAI.
    - If `opcode`=DB (STP) and `force_brk`=0, go to STP.
- `int_kind` clears to 00 on entry to FETCH following an injected sequence's `last_cycle`.
- `nmi_pending`:
  - Set on a sampled falling edge of `nmib` (registered on `phi2` edges, regardless of `rdy`).
  - Cleared when FETCH commits an NMI injection.
  - A new edge arriving in the same cycle as the clear keeps it set.
- WAI:
  - `halted`=1, `t_state` held.
  - Exit to FETCH when `nmi_pending`=1 or `irqb`=0, regardless of `i_flag`.
  - If `i_flag`=1, IRQ resumes without injection (next opcode executes).
- STP: `halted`=1; only `resb` exits.
- `pc_inc` is 0 in all states other than FETCH. In EXEC it is driven by the decoder, not this block.

Test Plan:
- Release `resb`, `rdy`=1, `phi2` every 4 `fclk`:
  - 7 cycles with `int_kind`=11 and `force_brk`=1.
  - Then `sync`=1, `t_state`=0, `int_kind`=00.
- `opcode`=A9 with `last_cycle` asserted at `t_state`=1:
  - `t_state` sequence 0,1,0.
  - `ir_signal` high only at `t_state`=0.
  - `pc_inc`=1 in FETCH.
- `rdy`=0 with `rw`=1 at `t_state`=2 for 3 `phi2` strobes: `t_state` stays 2; resumes to 3 after `rdy`=1.
- `rdy`=0 with `rw`=0 at `t_state`=2: no stall; `t_state` advances to 3.
- `nmib` falls during EXEC while `irqb`=0 and `i_flag`=0:
  - Next FETCH has `force_brk`=1, `pc_inc`=0, `int_kind`=10.
  - The following FETCH injects IRQ (`int_kind`=01).
- `opcode`=CB → `halted`=1 for 10 `phi2` strobes; `irqb`=0 with `i_flag`=1 → FETCH with no injection.
- `opcode`=DB → `halted` stays 1 despite NMI/IRQ.
- `resb` pulse mid-STP → RST sequence.
- No `last_cycle` ever asserted: FETCH is re-entered after `t_state`=7.
